// File: rtl/usb_hub_upstream_arbiter.sv
// rtl/usb_hub_upstream_arbiter.sv - round-robin per-packet arbiter for the upstream host transmit path
// Optional: define USB_HUB_BABBLE_LOCKOUT_EN to lock a babbling port out until it is disabled.
module usb_hub_upstream_arbiter #(
   parameter int NUM_USB_DEVICES   = 16,
   parameter int IDX_W             = $clog2(NUM_USB_DEVICES),
   parameter int MAX_PKT_CYCLES    = 1200,
   parameter int TURNAROUND_CYCLES = 4
) (
   input  logic                       hi_clock,
   input  logic                       reset,
   input  logic [NUM_USB_DEVICES-1:0] port_req,
   input  logic [NUM_USB_DEVICES-1:0] port_enable,
   input  logic [NUM_USB_DEVICES-1:0] port_eop,
   input  logic                       host_tx_busy,
   output logic [NUM_USB_DEVICES-1:0] grant,
   output logic                       grant_valid,
   output logic [IDX_W-1:0]           grant_idx,
   output logic                       babble_err,
   output logic [IDX_W-1:0]           babble_port,
   output logic                       arb_idle
);

   localparam int PKT_W = $clog2(MAX_PKT_CYCLES);
   localparam int GAP_W = $clog2(TURNAROUND_CYCLES + 1);
   localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(MAX_PKT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TURNAROUND_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

   state_t                     state, state_n;
   logic [PKT_W-1:0]           pkt_cnt, pkt_cnt_n;
   logic [GAP_W-1:0]           gap_cnt, gap_cnt_n;
   logic [IDX_W-1:0]           last_idx, last_idx_n;
   logic [NUM_USB_DEVICES-1:0] grant_n;
   logic                       grant_valid_n;
   logic [IDX_W-1:0]           grant_idx_n;
   logic                       babble_err_n;
   logic [IDX_W-1:0]           babble_port_n;
   logic                       arb_idle_n;
   logic [NUM_USB_DEVICES-1:0] lockout;
   logic [NUM_USB_DEVICES-1:0] eligible;
   logic                       found;
   logic [IDX_W-1:0]           winner;
   int                         pos;

`ifdef USB_HUB_BABBLE_LOCKOUT_EN
   logic [NUM_USB_DEVICES-1:0] lock_set;

   always_comb begin
      lock_set = '0;
      if (babble_err_n)
         lock_set[grant_idx] = 1'b1;
   end

   // A locked port is released by any cycle in which its enable is low.
   always_ff @(posedge hi_clock) begin
      if (reset)
         lockout <= '0;
      else
         lockout <= (lockout & port_enable) | lock_set;
   end
`else
   assign lockout = '0;
`endif

   assign eligible = port_req & port_enable & ~lockout;

   // Scan starts one past the last winner so the previous owner has lowest priority.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      pos    = 0;
      for (int k = 1; k <= NUM_USB_DEVICES; k++) begin
         pos = (int'(last_idx) + k) % NUM_USB_DEVICES;
         if (!found && eligible[pos]) begin
            found  = 1'b1;
            winner = IDX_W'(pos);
         end
      end
   end

   always_comb begin
      state_n       = state;
      pkt_cnt_n     = pkt_cnt;
      gap_cnt_n     = gap_cnt;
      last_idx_n    = last_idx;
      grant_n       = grant;
      grant_valid_n = grant_valid;
      grant_idx_n   = grant_idx;
      babble_err_n  = 1'b0;
      babble_port_n = babble_port;
      case (state)
         IDLE: begin
            if (found && !host_tx_busy) begin
               state_n         = ACTIVE;
               grant_n         = '0;
               grant_n[winner] = 1'b1;
               grant_valid_n   = 1'b1;
               grant_idx_n     = winner;
               last_idx_n      = winner;
               pkt_cnt_n       = '0;
            end
         end
         ACTIVE: begin
            if (pkt_cnt != PKT_LAST)
               pkt_cnt_n = pkt_cnt + 1'b1;
            if (port_eop[grant_idx] || !port_enable[grant_idx] || pkt_cnt == PKT_LAST) begin
               state_n       = GAP;
               grant_n       = '0;
               grant_valid_n = 1'b0;
               gap_cnt_n     = '0;
               if (!port_eop[grant_idx] && port_enable[grant_idx]) begin
                  babble_err_n  = 1'b1;
                  babble_port_n = grant_idx;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_n = IDLE;
            else
               gap_cnt_n = gap_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      arb_idle_n = (state_n == IDLE);
   end

   always_ff @(posedge hi_clock) begin
      if (reset) begin
         state       <= IDLE;
         pkt_cnt     <= '0;
         gap_cnt     <= '0;
         last_idx    <= IDX_W'(NUM_USB_DEVICES - 1);
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         babble_err  <= 1'b0;
         babble_port <= '0;
         arb_idle    <= 1'b1;
      end else begin
         state       <= state_n;
         pkt_cnt     <= pkt_cnt_n;
         gap_cnt     <= gap_cnt_n;
         last_idx    <= last_idx_n;
         grant       <= grant_n;
         grant_valid <= grant_valid_n;
         grant_idx   <= grant_idx_n;
         babble_err  <= babble_err_n;
         babble_port <= babble_port_n;
         arb_idle    <= arb_idle_n;
      end
   end

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// tb/tb_usb_hub_upstream_arbiter.sv - directed self-checking bench for usb_hub_upstream_arbiter
module tb_usb_hub_upstream_arbiter;

   logic        hi_clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] port_req = '0;
   logic [15:0] port_enable = '0;
   logic [15:0] port_eop = '0;
   logic        host_tx_busy = 1'b0;
   logic [15:0] grant;
   logic        grant_valid;
   logic [3:0]  grant_idx;
   logic        babble_err;
   logic [3:0]  babble_port;
   logic        arb_idle;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   usb_hub_upstream_arbiter dut (
      .hi_clock     (hi_clock),
      .reset        (reset),
      .port_req     (port_req),
      .port_enable  (port_enable),
      .port_eop     (port_eop),
      .host_tx_busy (host_tx_busy),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .babble_err   (babble_err),
      .babble_port  (babble_port),
      .arb_idle     (arb_idle)
   );

   always #5 hi_clock = ~hi_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hi_clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      port_req     = '0;
      port_eop     = '0;
      host_tx_busy = 1'b0;
      port_enable  = 16'hFFFF;
      tick();
      check("rst_drop_grant", grant_valid, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_grant(input string tag);
      int w;
      w = 0;
      do begin
         tick();
         w++;
      end while (!grant_valid && w < 40);
      check(tag, grant_valid, 1'b1);
   endtask

   initial begin
      int gt[4];
      int exp_idx[4];
      int bad;

      // Reset values
      reset       = 1'b1;
      port_enable = 16'hFFFF;
      tick();
      tick();
      check("rst_grant", grant, 16'h0000);
      check("rst_valid", grant_valid, 1'b0);
      check("rst_idx", grant_idx, 4'd0);
      check("rst_babble", babble_err, 1'b0);
      check("rst_bport", babble_port, 4'd0);
      check("rst_idle", arb_idle, 1'b1);
      reset = 1'b0;

      // Single packet on port 0, req dropped mid-packet, eop at cycle 10
      port_req = 16'h0001;
      tick();
      check("t1_grant", grant, 16'h0001);
      check("t1_idx", grant_idx, 4'd0);
      check("t1_valid", grant_valid, 1'b1);
      check("t1_idle", arb_idle, 1'b0);
      port_req = '0;
      repeat (9) tick();
      check("t1_hold", grant, 16'h0001);
      port_eop = 16'h0001;
      tick();
      port_eop = '0;
      check("t1_rel_grant", grant, 16'h0000);
      check("t1_rel_valid", grant_valid, 1'b0);
      check("t1_rel_idx", grant_idx, 4'd0);
      repeat (3) tick();
      check("t1_gap_c14", arb_idle, 1'b0);
      tick();
      check("t1_idle_c15", arb_idle, 1'b1);

      // Round robin 0,2,15,0 with eop 3 cycles after each grant
      do_reset();
      exp_idx = '{0, 2, 15, 0};
      port_req = 16'h8005;
      for (int i = 0; i < 4; i++) begin
         wait_grant($sformatf("t2_found%0d", i));
         gt[i] = cyc;
         check($sformatf("t2_idx%0d", i), grant_idx, exp_idx[i]);
         check($sformatf("t2_onehot%0d", i), grant, 32'h1 << exp_idx[i]);
         if (i > 0)
            check($sformatf("t2_space%0d", i), gt[i] - gt[i-1], 8);
         tick();
         tick();
         port_eop = 16'(32'h1 << exp_idx[i]);
         tick();
         port_eop = '0;
      end

      // Babble on port 3 exactly 1200 cycles after the grant edge
      do_reset();
      port_req = 16'h0008;
      tick();
      check("t3_grant", grant, 16'h0008);
      bad = 0;
      repeat (1199) begin
         tick();
         if (babble_err || !grant_valid)
            bad++;
      end
      check("t3_quiet", bad, 0);
      tick();
      check("t3_babble", babble_err, 1'b1);
      check("t3_bport", babble_port, 4'd3);
      check("t3_drop", grant, 16'h0000);
      tick();
      check("t3_pulse", babble_err, 1'b0);
      check("t3_bport_hold", babble_port, 4'd3);
`ifdef USB_HUB_BABBLE_LOCKOUT_EN
      bad = 0;
      repeat (20) begin
         tick();
         if (grant_valid)
            bad++;
      end
      check("t3_locked", bad, 0);
      port_enable = 16'hFFF7;
      tick();
      port_enable = 16'hFFFF;
      wait_grant("t3_unlock");
      check("t3_regrant", grant, 16'h0008);
`else
      repeat (3) tick();
      check("t3_gap_valid", grant_valid, 1'b0);
      check("t3_gap_idle", arb_idle, 1'b1);
      tick();
      check("t3_regrant", grant, 16'h0008);
`endif

      // eop coinciding with the timeout cycle wins over babble
      do_reset();
      port_req = 16'h0008;
      tick();
      check("t4_grant", grant, 16'h0008);
      repeat (1199) tick();
      port_eop = 16'h0008;
      port_req = '0;
      tick();
      port_eop = '0;
      check("t4_no_babble", babble_err, 1'b0);
      check("t4_drop", grant, 16'h0000);
      check("t4_gap", arb_idle, 1'b0);
      check("t4_bport", babble_port, 4'd0);
      tick();
      check("t4_no_babble2", babble_err, 1'b0);

      // host_tx_busy holds off the grant without losing the request
      do_reset();
      host_tx_busy = 1'b1;
      port_req = 16'h0010;
      bad = 0;
      repeat (20) begin
         tick();
         if (grant_valid)
            bad++;
      end
      check("t5_busy_hold", bad, 0);
      check("t5_busy_idle", arb_idle, 1'b1);
      host_tx_busy = 1'b0;
      tick();
      check("t5_grant", grant, 16'h0010);
      check("t5_idx", grant_idx, 4'd4);

      // Foreign eop ignored; disabling the granted port aborts without error
      port_eop = 16'h0020;
      tick();
      port_eop = '0;
      check("t6_foreign_eop", grant, 16'h0010);
      port_enable = 16'hFFEF;
      tick();
      check("t6_abort", grant, 16'h0000);
      check("t6_no_babble", babble_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
